gearbox_fifo: RTL and testbench
===============================

# gearbox_fifo

Parametrised width-converting FIFO: the next generation of the team's fixed 16-in/4-out buffer. It accepts IN_WIDTH-bit words and delivers OUT_WIDTH-bit words in either direction (wide-to-narrow or narrow-to-wide) with selectable lane order. It adds a fill-level output, an almost-full threshold, sticky overflow/underflow flags and a synchronous flush. It sits between the weight/activation loaders and the neuron datapath, repacking memory words into per-neuron operand widths and back.

## Interface
- IN_WIDTH, 16, write word width; IN_WIDTH and OUT_WIDTH must be integer multiples of one another
- OUT_WIDTH, 4, read word width
- DEPTH, 8, capacity in words of max(IN_WIDTH, OUT_WIDTH); power of two, ≥2
- MSB_FIRST, 1, 1: the most-significant lane leaves/arrives first; 0: the least-significant lane does
- AF_THRESH, DEPTH*R-IN_LANES, almost_full asserts when level ≥ AF_THRESH (lanes)
- Derived: LANE_W = min(IN_WIDTH, OUT_WIDTH); R = max/min ratio; IN_LANES = IN_WIDTH/LANE_W; OUT_LANES = OUT_WIDTH/LANE_W; CAP = DEPTH*R lanes
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush, active-high
- wr_en  in  1  write request
- data_in  in  IN_WIDTH  write word
- rd_en  in  1  read request
- data_out  out  OUT_WIDTH  read word
- empty  out  1  fewer than OUT_LANES lanes stored
- full  out  1  fewer than IN_LANES lanes free
- almost_full  out  1  level ≥ AF_THRESH
- level  out  clog2(CAP+1)  stored lanes
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: circular array of CAP lanes of LANE_W bits; write pointer and read pointer in lanes, modulo CAP (wrap at CAP-1 → 0).
- Write accepted when wr_en && !full: data_in is split into IN_LANES lanes, stored at wptr..wptr+IN_LANES-1 (mod CAP); lane order per MSB_FIRST (MSB_FIRST=1: data_in[IN_WIDTH-1 -: LANE_W] stored at wptr).
- Read accepted when rd_en && !empty: OUT_LANES lanes from rptr are concatenated; with MSB_FIRST=1 the lane at rptr occupies data_out MSBs.
- Write rejected while full: no state change except overflow←1. Read rejected while empty: underflow←1.
- Simultaneous read and write: each is judged against the pre-edge full/empty; both may be accepted; level += IN_LANES·wa − OUT_LANES·ra.
- A write to a full FIFO is rejected even if a read is accepted on the same edge.
- clr: pointers, level, overflow and underflow go to 0; it overrides wr_en/rd_en that cycle; data_out keeps its value.
- Flags are combinational from level: empty = level < OUT_LANES; full = level > CAP-IN_LANES; almost_full = level ≥ AF_THRESH.
- overflow/underflow are cleared only by rst or clr.

## Timing
- Reset values: data_out 0, level 0, empty 1, full 0, almost_full 0 (unless AF_THRESH=0), overflow 0, underflow 0.
- Default (registered read): data_out loads on the edge that accepts the read and is valid from the following cycle; it holds otherwise.
- level/empty/full update at the edge of the accepted operation. A written word is readable (empty=0) on the cycle after the write edge.
- rst asserted mid-operation: immediate return to reset values, with no completion of in-flight operations.

## Configuration
- GEARBOX_FIFO_FWFT_EN defined: first-word fall-through. data_out continuously presents the head OUT_LANES lanes while !empty (combinational from storage), rd_en pops them, and read latency is 0. data_out is 0 while empty.
- Undefined: registered read as described under Timing.

## Test plan
- 16→4, MSB_FIRST=1: reset, write 0xABCD, then 4 reads → data_out A, B, C, D on consecutive cycles. level goes 4,3,2,1,0 and empty reasserts after the 4th read.
- 16→4, write 8 words 0x0000..0x7777 → full=1, level=32, almost_full=1. A 9th write of 0xFFFF → overflow=1, level stays 32, and 32 reads return nibbles 0,0,0,0,1,…,7 with no F.
- 4→16, MSB_FIRST=0: write 0x1,0x2,0x3 → empty stays 1. A write of 0x4 → empty=0 next cycle, and a read returns 0x4321.
- Wrap and concurrency (16→4): fill to level 30 via repeated write/read pairs so the pointers wrap past CAP, then same-cycle wr_en+rd_en → level 30+4−1=33 is impossible and the write is rejected (full). At level 28, the same pair → level 31 with data integrity preserved.
- Read on an empty FIFO → underflow=1, data_out unchanged. clr → underflow=0, level=0, empty=1. Asserting rst mid-burst returns all outputs to reset values asynchronously.
- With GEARBOX_FIFO_FWFT_EN: write 0xABCD → data_out=A on the next cycle without rd_en, and each rd_en advances to B, C, D within the same cycle.

Source files
------------

// File: rtl/gearbox_fifo.sv
// gearbox_fifo: width-converting FIFO that repacks IN_WIDTH-bit words into
// OUT_WIDTH-bit words in either direction. Words are stored as LANE_W-bit
// lanes in a circular buffer of CAP lanes.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   clr         synchronous flush (pointers, level, sticky flags)
//   wr_en       write request, accepted when !full
//   data_in     IN_WIDTH-bit write word
//   rd_en       read request, accepted when !empty
//   data_out    OUT_WIDTH-bit read word
//   empty       fewer than OUT_LANES lanes stored
//   full        fewer than IN_LANES lanes free
//   almost_full level >= AF_THRESH
//   level       number of stored lanes
//   overflow    sticky: write attempted while full
//   underflow   sticky: read attempted while empty
//
// Build option: GEARBOX_FIFO_FWFT_EN selects first-word fall-through, where
// data_out shows the head lanes combinationally (0 while empty). Without it,
// data_out is a register loaded by each accepted read.
module gearbox_fifo #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 4,
  parameter int DEPTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int LANE_W    = (IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH,
  localparam int R         = ((IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH) / LANE_W,
  localparam int IN_LANES  = IN_WIDTH / LANE_W,
  localparam int OUT_LANES = OUT_WIDTH / LANE_W,
  localparam int CAP       = DEPTH * R,
  parameter int AF_THRESH  = CAP - IN_LANES,
  localparam int LW        = $clog2(CAP + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 rd_en,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [LW-1:0]        level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int PW = $clog2(CAP);
  localparam logic [PW:0]   CAP_P    = (PW+1)'(CAP);
  localparam logic [LW-1:0] IN_L     = LW'(IN_LANES);
  localparam logic [LW-1:0] OUT_L    = LW'(OUT_LANES);
  localparam logic [LW-1:0] FULL_LIM = LW'(CAP - IN_LANES);
  localparam logic [LW-1:0] AF_L     = LW'(AF_THRESH);

  // Lane index base+off modulo CAP; CAP need not be a power of two, so the
  // wrap is an explicit compare-and-subtract on a one-bit-wider sum.
  function automatic logic [PW-1:0] lane_idx(input logic [PW-1:0] base, input int off);
    logic [PW:0] sum_s;
    sum_s = {1'b0, base} + (PW+1)'(off);
    if (sum_s >= CAP_P) begin
      sum_s = sum_s - CAP_P;
    end else begin
      sum_s = sum_s;
    end
    return sum_s[PW-1:0];
  endfunction

  logic [LANE_W-1:0]    mem_r [CAP];
  logic [PW-1:0]        wptr_r;
  logic [PW-1:0]        rptr_r;
  logic [LW-1:0]        level_r;
  logic                 overflow_r;
  logic                 underflow_r;
  logic                 empty_s;
  logic                 full_s;
  logic                 wr_acc_s;
  logic                 rd_acc_s;
  logic [LW-1:0]        level_nxt_s;
  logic [OUT_WIDTH-1:0] rd_word_s;

  assign empty_s     = (level_r < OUT_L);
  assign full_s      = (level_r > FULL_LIM);
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (level_r >= AF_L);
  assign level       = level_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

  // Both operations are judged on pre-edge flags; flush suppresses both.
  assign wr_acc_s = wr_en && !full_s && !clr;
  assign rd_acc_s = rd_en && !empty_s && !clr;

  // Gather OUT_LANES head lanes into one output word in the chosen lane order.
  always_comb begin
    rd_word_s = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      if (MSB_FIRST) begin
        rd_word_s[OUT_WIDTH-1-j*LANE_W -: LANE_W] = mem_r[lane_idx(rptr_r, j)];
      end else begin
        rd_word_s[j*LANE_W +: LANE_W] = mem_r[lane_idx(rptr_r, j)];
      end
    end
  end

  // Next fill level from the accepted write/read pair.
  always_comb begin
    level_nxt_s = level_r;
    if (wr_acc_s) begin
      level_nxt_s = level_nxt_s + IN_L;
    end else begin
      level_nxt_s = level_nxt_s;
    end
    if (rd_acc_s) begin
      level_nxt_s = level_nxt_s - OUT_L;
    end else begin
      level_nxt_s = level_nxt_s;
    end
  end

  // Lane storage: split an accepted write word into consecutive lanes.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      for (int i = 0; i < IN_LANES; i++) begin
        mem_r[lane_idx(wptr_r, i)] <= MSB_FIRST ? data_in[IN_WIDTH-1-i*LANE_W -: LANE_W]
                                                : data_in[i*LANE_W +: LANE_W];
      end
    end
  end

  // Pointers, level and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      level_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (clr) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      level_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wptr_r <= lane_idx(wptr_r, IN_LANES);
      end
      if (rd_acc_s) begin
        rptr_r <= lane_idx(rptr_r, OUT_LANES);
      end
      level_r <= level_nxt_s;
      if (wr_en && full_s) begin
        overflow_r <= 1'b1;
      end
      if (rd_en && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

`ifdef GEARBOX_FIFO_FWFT_EN
  assign data_out = empty_s ? '0 : rd_word_s;
`else
  logic [OUT_WIDTH-1:0] data_out_r;

  // Registered read port: loads on an accepted read, holds otherwise
  // (including across a flush).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_r <= '0;
    end else if (rd_acc_s) begin
      data_out_r <= rd_word_s;
    end
  end

  assign data_out = data_out_r;
`endif

endmodule

// File: tb/tb_gearbox_fifo.sv
// Scoreboard bench for gearbox_fifo: instance A is 16->4 MSB-first (default
// parameters), instance B is 4->16 LSB-first. Expected nibbles of A are
// queued when a write is issued; a monitor pops and compares on every read
// the DUT accepts.
module tb_gearbox_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_clr, a_wr_en, a_rd_en;
  logic [15:0] a_din;
  logic [3:0]  a_dout;
  logic        a_empty, a_full, a_af, a_ovf, a_unf;
  logic [5:0]  a_level;

  logic        b_clr, b_wr_en, b_rd_en;
  logic [3:0]  b_din;
  logic [15:0] b_dout;
  logic        b_empty, b_full, b_af, b_ovf, b_unf;
  logic [5:0]  b_level;

  gearbox_fifo u_a (
    .clk(clk), .rst(rst), .clr(a_clr), .wr_en(a_wr_en), .data_in(a_din),
    .rd_en(a_rd_en), .data_out(a_dout), .empty(a_empty), .full(a_full),
    .almost_full(a_af), .level(a_level), .overflow(a_ovf), .underflow(a_unf)
  );

  gearbox_fifo #(.IN_WIDTH(4), .OUT_WIDTH(16), .DEPTH(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr), .wr_en(b_wr_en), .data_in(b_din),
    .rd_en(b_rd_en), .data_out(b_dout), .empty(b_empty), .full(b_full),
    .almost_full(b_af), .level(b_level), .overflow(b_ovf), .underflow(b_unf)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];
  bit acc_prev = 1'b0;

  logic [15:0] wt [11] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC,
                           16'hBA98, 16'h7654, 16'h3210, 16'h5A5A, 16'hA5C3,
                           16'h9E1F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp();
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rd_data actual=%0h expected=<none queued>", a_dout);
    end else begin
      e = exp_q.pop_front();
      check("rd_data", 32'(a_dout), 32'(e));
    end
  endtask

  // Monitor: compare A's output word for every read the DUT accepts.
  always @(negedge clk) begin
`ifdef GEARBOX_FIFO_FWFT_EN
    if (rst && !a_clr && a_rd_en && !a_empty) pop_cmp();
`else
    if (acc_prev && rst) pop_cmp();
    acc_prev = rst && !a_clr && a_rd_en && !a_empty;
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [15:0] d, input bit acc);
    a_din = d;
    a_wr_en = 1'b1;
    if (acc) begin
      exp_q.push_back(d[15:12]);
      exp_q.push_back(d[11:8]);
      exp_q.push_back(d[7:4]);
      exp_q.push_back(d[3:0]);
    end
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic a_pair(input logic [15:0] d, input bit acc);
    a_rd_en = 1'b1;
    a_write(d, acc);
    a_rd_en = 1'b0;
  endtask

  task automatic a_reads(input int n);
    a_rd_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    a_rd_en = 1'b0;
  endtask

  task automatic b_write(input logic [3:0] d);
    b_din = d;
    b_wr_en = 1'b1;
    tick();
    b_wr_en = 1'b0;
  endtask

  task automatic a_check_reset(input string tag);
    check({tag, "_dout"},  32'(a_dout),  32'd0);
    check({tag, "_level"}, 32'(a_level), 32'd0);
    check({tag, "_empty"}, 32'(a_empty), 32'd1);
    check({tag, "_full"},  32'(a_full),  32'd0);
    check({tag, "_af"},    32'(a_af),    32'd0);
    check({tag, "_ovf"},   32'(a_ovf),   32'd0);
    check({tag, "_unf"},   32'(a_unf),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nib;
    rst = 1'b0;
    a_clr = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_din = 16'h0000;
    b_clr = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_din = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    a_check_reset("rst");
    check("b_rst_empty", 32'(b_empty), 32'd1);
    check("b_rst_dout",  32'(b_dout),  32'd0);
    rst = 1'b1;

    // 4->16 LSB-first: a word forms only after four lanes.
    b_write(4'h1);
    b_write(4'h2);
    b_write(4'h3);
    check("b_empty_3", 32'(b_empty), 32'd1);
    check("b_level_3", 32'(b_level), 32'd3);
    b_write(4'h4);
    check("b_empty_4", 32'(b_empty), 32'd0);
    check("b_level_4", 32'(b_level), 32'd4);
`ifdef GEARBOX_FIFO_FWFT_EN
    check("b_dout_head", 32'(b_dout), 32'h4321);
`endif
    b_rd_en = 1'b1;
    tick();
    b_rd_en = 1'b0;
`ifdef GEARBOX_FIFO_FWFT_EN
    check("b_dout_after", 32'(b_dout), 32'h0);
`else
    check("b_dout_after", 32'(b_dout), 32'h4321);
`endif
    check("b_empty_rd", 32'(b_empty), 32'd1);
    check("b_level_rd", 32'(b_level), 32'd0);

    // 16->4: one word, four reads.
    a_write(16'hABCD, 1'b1);
    check("t1_level", 32'(a_level), 32'd4);
    check("t1_empty", 32'(a_empty), 32'd0);
`ifdef GEARBOX_FIFO_FWFT_EN
    check("t1_dout_fall", 32'(a_dout), 32'hA);
`else
    check("t1_dout_hold", 32'(a_dout), 32'h0);
`endif
    a_rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_level_rd", 32'(a_level), 32'(3 - k));
    end
    a_rd_en = 1'b0;
    check("t1_empty_end", 32'(a_empty), 32'd1);

    // Underflow then flush.
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    check("t2_unf", 32'(a_unf), 32'd1);
`ifdef GEARBOX_FIFO_FWFT_EN
    check("t2_dout", 32'(a_dout), 32'h0);
`else
    check("t2_dout", 32'(a_dout), 32'hD);
`endif
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("t2_clr_unf",   32'(a_unf),   32'd0);
    check("t2_clr_level", 32'(a_level), 32'd0);
    check("t2_clr_empty", 32'(a_empty), 32'd1);

    // Fill to capacity, overflow, drain.
    for (int k = 0; k < 8; k++) begin
      nib = 4'(k);
      a_write({4{nib}}, 1'b1);
      if (k == 5) check("t3_af_24", 32'(a_af), 32'd0);
      if (k == 6) begin
        check("t3_af_28",   32'(a_af),   32'd1);
        check("t3_full_28", 32'(a_full), 32'd0);
      end
    end
    check("t3_full",  32'(a_full),  32'd1);
    check("t3_level", 32'(a_level), 32'd32);
    check("t3_af",    32'(a_af),    32'd1);
    a_write(16'hFFFF, 1'b0);
    check("t3_ovf",       32'(a_ovf),   32'd1);
    check("t3_level_ovf", 32'(a_level), 32'd32);
    a_reads(32);
    check("t3_level_end", 32'(a_level), 32'd0);
    check("t3_empty_end", 32'(a_empty), 32'd1);
    check("t3_ovf_sticky", 32'(a_ovf), 32'd1);
    tick();
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("t3_clr_ovf", 32'(a_ovf), 32'd0);

    // Wrap and concurrency.
    a_write(wt[0], 1'b1);
    for (int i = 1; i <= 8; i++) a_pair(wt[i], 1'b1);
    check("t4_level_28", 32'(a_level), 32'd28);
    check("t4_full_28",  32'(a_full),  32'd0);
    a_pair(wt[9], 1'b1);
    check("t4_level_31", 32'(a_level), 32'd31);
    check("t4_full_31",  32'(a_full),  32'd1);
    a_reads(1);
    check("t4_level_30", 32'(a_level), 32'd30);
    a_pair(wt[10], 1'b0);
    check("t4_level_29", 32'(a_level), 32'd29);
    check("t4_ovf",      32'(a_ovf),   32'd1);
    a_reads(29);
    check("t4_level_end", 32'(a_level), 32'd0);
    check("t4_empty_end", 32'(a_empty), 32'd1);
    tick();
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-burst.
    a_rd_en = 1'b1;
    tick();
    a_rd_en = 1'b0;
    check("t5_unf", 32'(a_unf), 32'd1);
    a_write(16'h1357, 1'b1);
    a_write(16'h2468, 1'b1);
    a_rd_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    a_rd_en = 1'b0;
    exp_q.delete();
    a_check_reset("t5");
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("t5_level_rel", 32'(a_level), 32'd0);
    check("t5_empty_rel", 32'(a_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
